// File: rtl/cache_pkg.sv
// cache_pkg: shared constants for the cache port arbiter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: FSM state encoding (ST_*), state enum, cache opcode constants RD/WR.
package cache_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_BUSY    = ST_BUSY,
    S_RELEASE = ST_RELEASE
  } arb_state_t;

  // Cache rd_wrt_ca opcodes.
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: bundle of the two requester ports and the cache-side signals.
// Latency: n/a (wiring only).
// Backpressure: req held until ack/err; the arbiter owns ca_* while an access is in flight.
// Modports: slave = arbiter (serves the ports, drives the cache); master = requesters + cache.
// Option: CACHE_ARB_STATS_EN adds gnt_cnt0/gnt_cnt1/to_cnt statistics signals.
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0, req1;
  logic              rdwr0, rdwr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              err0, err1;
  logic              ca_enable;
  logic              ca_rdwr;
  logic [ADDR_W-1:0] ca_addr;
  logic [DATA_W-1:0] ca_wdata;
  logic [DATA_W-1:0] ca_rdata;
  logic              ca_done;
`ifdef CACHE_ARB_STATS_EN
  logic [15:0]       gnt_cnt0, gnt_cnt1;
  logic [7:0]        to_cnt;
`endif

  modport slave (
    input  req0, req1, rdwr0, rdwr1, addr0, addr1, wdata0, wdata1, ca_rdata, ca_done,
    output ack0, ack1, rdata0, rdata1, err0, err1, ca_enable, ca_rdwr, ca_addr, ca_wdata
`ifdef CACHE_ARB_STATS_EN
    , output gnt_cnt0, gnt_cnt1, to_cnt
`endif
  );

  modport master (
    output req0, req1, rdwr0, rdwr1, addr0, addr1, wdata0, wdata1, ca_rdata, ca_done,
    input  ack0, ack1, rdata0, rdata1, err0, err1, ca_enable, ca_rdwr, ca_addr, ca_wdata
`ifdef CACHE_ARB_STATS_EN
    , input gnt_cnt0, gnt_cnt1, to_cnt
`endif
  );

endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin selector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req0/req1 requests, last_gnt previous winner -> gnt winning port index, valid any request.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    // On a tie the port that did not win last time goes next; otherwise the
    // sole requester wins (gnt is don't-care when valid is low).
    if (req0 && req1) gnt = ~last_gnt;
    else              gnt = req1;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin share of one cache between fetch (port 0) and LSU (port 1).
// Latency: grant 1 cycle after req; ack/err 1 cycle after ca_done/watchdog expiry; then 1 RELEASE cycle.
// Backpressure: a port keeps req high while the other owns the cache; one access in flight.
// Ports: clk, rst (async active-low), bus (cache_port_arbiter_if.slave: per-port req/rdwr/addr/wdata in,
//        ack/err/rdata out; ca_enable/ca_rdwr/ca_addr/ca_wdata to the cache, ca_rdata/ca_done back).
// Option: define CACHE_ARB_STATS_EN for grant/timeout counters gnt_cnt0, gnt_cnt1, to_cnt.
module cache_port_arbiter #(
  parameter int WDOG_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  cache_port_arbiter_if.slave bus
);
  import cache_pkg::*;

  arb_state_t        state, state_nxt;
  logic              last_gnt;
  logic [WDOG_W-1:0] wdog, wdog_inc;
  logic              pick_gnt, pick_vld;
  logic              do_grant, do_done, do_to;

  rr_pick2 u_pick (
    .req0     (bus.req0),
    .req1     (bus.req1),
    .last_gnt (last_gnt),
    .gnt      (pick_gnt),
    .valid    (pick_vld)
  );

  assign wdog_inc = wdog + 1'b1;

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    do_to     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          do_grant  = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // Completion wins over a watchdog expiry landing in the same cycle.
        if (bus.ca_done) begin
          do_done   = 1'b1;
          state_nxt = S_RELEASE;
        end else if (wdog_inc == '1) begin
          do_to     = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      // ca_enable is already low here; this cycle lets the cache drop done
      // so a stale done is never taken as the next access's completion.
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      last_gnt      <= 1'b1;
      wdog          <= '0;
      bus.ca_enable <= 1'b0;
      bus.ca_rdwr   <= 1'b0;
      bus.ca_addr   <= '0;
      bus.ca_wdata  <= '0;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.err0      <= 1'b0;
      bus.err1      <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
    end else begin
      state    <= state_nxt;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.err0 <= 1'b0;
      bus.err1 <= 1'b0;
      if (state == S_BUSY) wdog <= wdog_inc;
      if (do_grant) begin
        last_gnt      <= pick_gnt;
        wdog          <= '0;
        bus.ca_enable <= 1'b1;
        bus.ca_rdwr   <= pick_gnt ? bus.rdwr1  : bus.rdwr0;
        bus.ca_addr   <= pick_gnt ? bus.addr1  : bus.addr0;
        bus.ca_wdata  <= pick_gnt ? bus.wdata1 : bus.wdata0;
      end
      // last_gnt doubles as the owner of the access in flight.
      if (do_done) begin
        bus.ca_enable <= 1'b0;
        if (last_gnt) begin
          bus.ack1 <= 1'b1;
          if (bus.ca_rdwr == RD) bus.rdata1 <= bus.ca_rdata;
        end else begin
          bus.ack0 <= 1'b1;
          if (bus.ca_rdwr == RD) bus.rdata0 <= bus.ca_rdata;
        end
      end
      if (do_to) begin
        bus.ca_enable <= 1'b0;
        if (last_gnt) bus.err1 <= 1'b1;
        else          bus.err0 <= 1'b1;
      end
    end
  end

`ifdef CACHE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.gnt_cnt0 <= '0;
      bus.gnt_cnt1 <= '0;
      bus.to_cnt   <= '0;
    end else begin
      if (do_grant && !pick_gnt) bus.gnt_cnt0 <= bus.gnt_cnt0 + 16'd1;
      if (do_grant &&  pick_gnt) bus.gnt_cnt1 <= bus.gnt_cnt1 + 16'd1;
      if (do_to && bus.to_cnt != 8'hFF) bus.to_cnt <= bus.to_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed scenarios plus randomized two-port traffic for cache_port_arbiter.
// Latency: n/a (testbench).
// Backpressure: behavioural cache with programmable hit latency; done can be withheld.
module tb_cache_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bif ();

  cache_port_arbiter #(.WDOG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int          vecs = 0;
  int          errs = 0;
  logic [15:0] cmem [256];
  logic [15:0] smem [256];
  int          cache_lat = 0;
  bit          done_en = 1'b1;
  int          ccnt = 0;
  bit          m_last;
  logic [15:0] exp_rd0, exp_rd1;

  // Behavioural cache: done registered, raised once per enable after cache_lat cycles, held while enabled.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bif.ca_done  <= 1'b0;
      bif.ca_rdata <= '0;
      ccnt = 0;
    end else if (!bif.ca_enable) begin
      bif.ca_done <= 1'b0;
      ccnt = 0;
    end else begin
      if (done_en && !bif.ca_done && ccnt >= cache_lat) begin
        bif.ca_done <= 1'b1;
        if (bif.ca_rdwr) bif.ca_rdata <= cmem[bif.ca_addr[7:0]];
        else             cmem[bif.ca_addr[7:0]] = bif.ca_wdata;
      end
      ccnt = ccnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bif.req0 = 1'b1; bif.rdwr0 = 1'b1; bif.addr0 = 16'h0040;
    rst = 1'b0;
    step(); step();
    vecs++; if (bif.ca_enable !== 1'b0) begin errs++; $display("FAIL reset_ca_enable got %b want 0", bif.ca_enable); end
    vecs++; if (bif.ca_rdwr !== 1'b0) begin errs++; $display("FAIL reset_ca_rdwr got %b want 0", bif.ca_rdwr); end
    vecs++; if (bif.ca_addr !== 16'h0) begin errs++; $display("FAIL reset_ca_addr got %h want 0", bif.ca_addr); end
    vecs++; if (bif.ca_wdata !== 16'h0) begin errs++; $display("FAIL reset_ca_wdata got %h want 0", bif.ca_wdata); end
    vecs++; if ({bif.ack0, bif.ack1} !== 2'b00) begin errs++; $display("FAIL reset_ack got %b want 00", {bif.ack0, bif.ack1}); end
    vecs++; if ({bif.err0, bif.err1} !== 2'b00) begin errs++; $display("FAIL reset_err got %b want 00", {bif.err0, bif.err1}); end
    vecs++; if (bif.rdata0 !== 16'h0) begin errs++; $display("FAIL reset_rdata0 got %h want 0", bif.rdata0); end
    vecs++; if (bif.rdata1 !== 16'h0) begin errs++; $display("FAIL reset_rdata1 got %h want 0", bif.rdata1); end
`ifdef CACHE_ARB_STATS_EN
    vecs++; if ({bif.gnt_cnt0, bif.gnt_cnt1, bif.to_cnt} !== 40'h0) begin errs++; $display("FAIL reset_stats got %h want 0", {bif.gnt_cnt0, bif.gnt_cnt1, bif.to_cnt}); end
`endif
    bif.req0 = 1'b0;
    rst = 1'b1;
    m_last = 1'b1;
    exp_rd0 = '0; exp_rd1 = '0;
    step();
  endtask

  task automatic test_single_read();
    cmem[8'h40] = 16'hBEEF;
    bif.req0 = 1'b1; bif.rdwr0 = 1'b1; bif.addr0 = 16'h0040;
    step();
    vecs++; if ({bif.ca_enable, bif.ca_rdwr, bif.ca_addr} !== {2'b11, 16'h0040}) begin errs++; $display("FAIL read_grant got %b/%b/%h want 1/1/0040", bif.ca_enable, bif.ca_rdwr, bif.ca_addr); end
    step();
    vecs++; if (bif.ack0 !== 1'b0) begin errs++; $display("FAIL read_early_ack got %b want 0", bif.ack0); end
    step();
    vecs++; if (bif.ack0 !== 1'b1) begin errs++; $display("FAIL read_ack got %b want 1", bif.ack0); end
    vecs++; if (bif.rdata0 !== 16'hBEEF) begin errs++; $display("FAIL read_rdata got %h want beef", bif.rdata0); end
    vecs++; if (bif.ca_enable !== 1'b0) begin errs++; $display("FAIL read_release_en got %b want 0", bif.ca_enable); end
    bif.req0 = 1'b0;
    step();
    vecs++; if ({bif.ca_enable, bif.ack0} !== 2'b00) begin errs++; $display("FAIL read_after got en/ack %b want 00", {bif.ca_enable, bif.ack0}); end
    vecs++; if (bif.rdata0 !== 16'hBEEF) begin errs++; $display("FAIL read_hold got %h want beef", bif.rdata0); end
    exp_rd0 = 16'hBEEF;
    m_last = 1'b0;
  endtask

  task automatic test_simultaneous();
    int order[$];
    int ack_cyc[$];
    int g1_cyc;
    rst = 1'b0; step(); rst = 1'b1; m_last = 1'b1;
    bif.req0 = 1'b1; bif.rdwr0 = 1'b1; bif.addr0 = 16'h0011;
    bif.req1 = 1'b1; bif.rdwr1 = 1'b1; bif.addr1 = 16'h0022;
    g1_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bif.ca_enable && bif.ca_addr == 16'h0022 && g1_cyc < 0) g1_cyc = c;
      if (bif.ack0) begin order.push_back(0); ack_cyc.push_back(c); bif.req0 = 1'b0; end
      if (bif.ack1) begin order.push_back(1); ack_cyc.push_back(c); bif.req1 = 1'b0; end
    end
    vecs++;
    if (order.size() != 2) begin errs++; $display("FAIL simul_ack_count got %0d want 2", order.size()); end
    else begin
      vecs++; if (order[0] != 0 || order[1] != 1) begin errs++; $display("FAIL simul_order got %0d,%0d want 0,1", order[0], order[1]); end
      vecs++; if (ack_cyc[0] != 3 || ack_cyc[1] != 7) begin errs++; $display("FAIL simul_ack_cycles got %0d,%0d want 3,7", ack_cyc[0], ack_cyc[1]); end
    end
    vecs++; if (g1_cyc != 5) begin errs++; $display("FAIL simul_port1_grant got cycle %0d want 5", g1_cyc); end
    exp_rd0 = cmem[8'h11]; exp_rd1 = cmem[8'h22];
    vecs++; if ({bif.rdata0, bif.rdata1} !== {exp_rd0, exp_rd1}) begin errs++; $display("FAIL simul_rdata got %h/%h want %h/%h", bif.rdata0, bif.rdata1, exp_rd0, exp_rd1); end
    m_last = 1'b1;
  endtask

  task automatic test_alternate();
    int grants = 0;
    int acks = 0;
    bit prev_en = 1'b0;
    bit w;
    bif.req0 = 1'b1; bif.rdwr0 = 1'b1; bif.addr0 = 16'h0031;
    bif.req1 = 1'b1; bif.rdwr1 = 1'b1; bif.addr1 = 16'h0032;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      step();
      if (bif.ca_enable && !prev_en) begin
        w = ~m_last; m_last = w; grants++;
        vecs++; if (bif.ca_addr !== (w ? 16'h0032 : 16'h0031)) begin errs++; $display("FAIL alt_grant%0d got addr %h want port %0d", grants, bif.ca_addr, w); end
      end
      prev_en = bif.ca_enable;
      if (bif.ack0) acks++;
      if (bif.ack1) acks++;
      if (acks == 4) begin bif.req0 = 1'b0; bif.req1 = 1'b0; end
    end
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    vecs++; if (acks != 4 || grants != 4) begin errs++; $display("FAIL alt_count got acks %0d grants %0d want 4 4", acks, grants); end
    step(); step(); step();
    vecs++; if (bif.ca_enable !== 1'b0) begin errs++; $display("FAIL alt_extra_grant got en %b want 0", bif.ca_enable); end
    exp_rd0 = cmem[8'h31]; exp_rd1 = cmem[8'h32];
    vecs++; if ({bif.rdata0, bif.rdata1} !== {exp_rd0, exp_rd1}) begin errs++; $display("FAIL alt_rdata got %h/%h want %h/%h", bif.rdata0, bif.rdata1, exp_rd0, exp_rd1); end
  endtask

  task automatic test_write_miss();
    int en_cyc = 0;
    int acks = 0;
    int bad = 0;
    cache_lat = 19;
    bif.req1 = 1'b1; bif.rdwr1 = 1'b0; bif.addr1 = 16'h0100; bif.wdata1 = 16'h1234;
    for (int c = 0; c < 60; c++) begin
      step();
      if (bif.ca_enable) begin
        en_cyc++;
        vecs++; if ({bif.ca_rdwr, bif.ca_addr, bif.ca_wdata} !== {1'b0, 16'h0100, 16'h1234}) begin errs++; $display("FAIL wr_hold cyc %0d got %b/%h/%h want 0/0100/1234", c, bif.ca_rdwr, bif.ca_addr, bif.ca_wdata); end
      end
      if (bif.ack1) begin acks++; bif.req1 = 1'b0; end
      if (bif.ack0 || bif.err0 || bif.err1) bad++;
    end
    vecs++; if (en_cyc != 21) begin errs++; $display("FAIL wr_busy_len got %0d want 21", en_cyc); end
    vecs++; if (acks != 1 || bad != 0) begin errs++; $display("FAIL wr_ack got acks %0d stray %0d want 1 0", acks, bad); end
    vecs++; if (bif.rdata1 !== exp_rd1) begin errs++; $display("FAIL wr_rdata1 got %h want %h", bif.rdata1, exp_rd1); end
    vecs++; if (cmem[8'h00] !== 16'h1234) begin errs++; $display("FAIL wr_cache_data got %h want 1234", cmem[8'h00]); end
    cache_lat = 0;
    m_last = 1'b1;
  endtask

  task automatic test_timeout();
    int en_cyc = 0;
    int errs0 = 0;
    int acks0 = 0;
    int acks1 = 0;
    bit seen = 1'b0;
    done_en = 1'b0;
    bif.req0 = 1'b1; bif.rdwr0 = 1'b1; bif.addr0 = 16'h0050;
    for (int c = 0; c < 300; c++) begin
      step();
      if (bif.ca_enable) en_cyc++;
      if (bif.err0) begin errs0++; bif.req0 = 1'b0; end
      if (bif.ack0) acks0++;
    end
    bif.req0 = 1'b0;
    vecs++; if (en_cyc != 255) begin errs++; $display("FAIL to_busy_len got %0d want 255", en_cyc); end
    vecs++; if (errs0 != 1 || acks0 != 0) begin errs++; $display("FAIL to_pulse got err %0d ack %0d want 1 0", errs0, acks0); end
    vecs++; if (bif.rdata0 !== exp_rd0) begin errs++; $display("FAIL to_rdata0 got %h want %h", bif.rdata0, exp_rd0); end
    done_en = 1'b1;
    m_last = 1'b0;
    bif.req1 = 1'b1; bif.rdwr1 = 1'b1; bif.addr1 = 16'h0060;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bif.ca_enable && !seen) begin
        seen = 1'b1;
        vecs++; if (bif.ca_addr !== 16'h0060) begin errs++; $display("FAIL to_next_grant got %h want 0060", bif.ca_addr); end
      end
      if (bif.ack1) begin acks1++; bif.req1 = 1'b0; end
    end
    exp_rd1 = cmem[8'h60];
    vecs++; if (acks1 != 1 || bif.rdata1 !== exp_rd1) begin errs++; $display("FAIL to_next_ack got %0d/%h want 1/%h", acks1, bif.rdata1, exp_rd1); end
    m_last = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    int acks = 0;
    int bad = 0;
    bit seen = 1'b0;
    cache_lat = 50;
    bif.req0 = 1'b1; bif.rdwr0 = 1'b1; bif.addr0 = 16'h0070;
    step();
    vecs++; if (bif.ca_enable !== 1'b1) begin errs++; $display("FAIL rstmid_grant got %b want 1", bif.ca_enable); end
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    vecs++; if ({bif.ca_enable, bif.ack0, bif.err0} !== 3'b000) begin errs++; $display("FAIL rstmid_async got en/ack/err %b want 000", {bif.ca_enable, bif.ack0, bif.err0}); end
    bif.req0 = 1'b0;
    step(); step();
    rst = 1'b1;
    cache_lat = 0;
    m_last = 1'b1;
    bif.req1 = 1'b1; bif.rdwr1 = 1'b1; bif.addr1 = 16'h0080;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bif.ca_enable && !seen) begin
        seen = 1'b1;
        vecs++; if (bif.ca_addr !== 16'h0080) begin errs++; $display("FAIL rstmid_grant1 got %h want 0080", bif.ca_addr); end
      end
      if (bif.ack1) begin acks++; bif.req1 = 1'b0; end
      if (bif.ack0 || bif.err0 || bif.err1) bad++;
    end
    exp_rd0 = '0; exp_rd1 = cmem[8'h80];
    vecs++; if (acks != 1 || bad != 0) begin errs++; $display("FAIL rstmid_ack got %0d stray %0d want 1 0", acks, bad); end
    vecs++; if ({bif.rdata0, bif.rdata1} !== {exp_rd0, exp_rd1}) begin errs++; $display("FAIL rstmid_rdata got %h/%h want %h/%h", bif.rdata0, bif.rdata1, exp_rd0, exp_rd1); end
`ifdef CACHE_ARB_STATS_EN
    vecs++; if ({bif.gnt_cnt0, bif.gnt_cnt1, bif.to_cnt} !== {16'd0, 16'd1, 8'd0}) begin errs++; $display("FAIL rstmid_stats got %0d/%0d/%0d want 0/1/0", bif.gnt_cnt0, bif.gnt_cnt1, bif.to_cnt); end
`endif
  endtask

  // Random traffic: the model predicts each grant from the request lines seen
  // before the grant edge and the previous winner, and tracks memory contents.
  task automatic test_random();
    bit          r_req [2];
    bit          r_rw  [2];
    logic [15:0] r_addr[2];
    logic [15:0] r_wd  [2];
    int          wt    [2];
    bit          pre   [2];
    logic [15:0] exp_rd[2];
    logic [15:0] rdp;
    bit          prev_en = 1'b0;
    bit          w;
    bit          owner = 1'b0;
    bit          ackp, errp;
    int          ndone = 0;
    for (int i = 0; i < 256; i++) smem[i] = cmem[i];
    exp_rd[0] = exp_rd0; exp_rd[1] = exp_rd1;
    for (int p = 0; p < 2; p++) begin r_req[p] = 1'b0; wt[p] = 0; r_rw[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0; end
    for (int c = 0; c < 3000 && ndone < 40; c++) begin
      pre[0] = r_req[0]; pre[1] = r_req[1];
      step();
      if (bif.ca_enable && !prev_en) begin
        if (pre[0] && pre[1]) w = ~m_last;
        else                  w = pre[1];
        vecs++;
        if (!(pre[0] || pre[1]) || {bif.ca_rdwr, bif.ca_addr, bif.ca_wdata} !== {r_rw[w], r_addr[w], r_wd[w]}) begin
          errs++; $display("FAIL rand_grant cyc %0d got %b/%h/%h want port %0d %b/%h/%h", c, bif.ca_rdwr, bif.ca_addr, bif.ca_wdata, w, r_rw[w], r_addr[w], r_wd[w]);
        end
        m_last = w; owner = w;
        cache_lat = $urandom_range(0, 3);
      end
      prev_en = bif.ca_enable;
      for (int p = 0; p < 2; p++) begin
        ackp = (p == 1) ? bif.ack1 : bif.ack0;
        errp = (p == 1) ? bif.err1 : bif.err0;
        rdp  = (p == 1) ? bif.rdata1 : bif.rdata0;
        if (errp) begin vecs++; errs++; $display("FAIL rand_err port %0d got 1 want 0", p); end
        if (ackp) begin
          if (r_rw[p]) exp_rd[p] = smem[r_addr[p][7:0]];
          else         smem[r_addr[p][7:0]] = r_wd[p];
          vecs++;
          if (p != int'(owner) || rdp !== exp_rd[p]) begin
            errs++; $display("FAIL rand_ack port %0d got rdata %h owner %0d want %h", p, rdp, owner, exp_rd[p]);
          end
          r_req[p] = 1'b0; wt[p] = $urandom_range(0, 2); ndone++;
        end else if (!r_req[p]) begin
          if (wt[p] == 0) begin
            r_req[p]  = 1'b1;
            r_rw[p]   = 1'($urandom_range(0, 1));
            r_addr[p] = 16'($urandom_range(0, 15));
            r_wd[p]   = 16'($urandom);
          end else wt[p]--;
        end
      end
      bif.req0 = r_req[0]; bif.rdwr0 = r_rw[0]; bif.addr0 = r_addr[0]; bif.wdata0 = r_wd[0];
      bif.req1 = r_req[1]; bif.rdwr1 = r_rw[1]; bif.addr1 = r_addr[1]; bif.wdata1 = r_wd[1];
    end
    bif.req0 = 1'b0; bif.req1 = 1'b0;
    vecs++; if (ndone < 40) begin errs++; $display("FAIL rand_progress got %0d want 40", ndone); end
  endtask

  initial begin
    rst = 1'b1;
    bif.req0 = 1'b0; bif.rdwr0 = 1'b0; bif.addr0 = '0; bif.wdata0 = '0;
    bif.req1 = 1'b0; bif.rdwr1 = 1'b0; bif.addr1 = '0; bif.wdata1 = '0;
    for (int i = 0; i < 256; i++) cmem[i] = 16'(i * 409) ^ 16'hA5C3;
    #2;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_alternate();
    test_write_miss();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
